// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared constants, types and helpers for the FFT front-end.
//   FFT_DW   : default sample width in bits (signed two's complement)
//   FFT_N    : default frame length, must match the FFT size (power of two)
//   FFT_LOGN : log2(FFT_N)
//   sample_t : one signed sample
//   frame_t  : N samples, lane k in element k
//   bitrev   : reverse the low 'bits' bits of an index
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_DW   = 8;
    localparam int FFT_N    = 8;
    localparam int FFT_LOGN = $clog2(FFT_N);

    typedef logic signed [FFT_DW-1:0] sample_t;
    typedef sample_t [FFT_N-1:0]      frame_t;

    // Bit-reversal of an index, used to present frames in the order
    // a decimation-in-time FFT expects.
    function automatic int bitrev(input int k, input int bits);
        int r;
        r = 0;
        for (int b = 0; b < bits; b++) begin
            r = r | (((k >> b) & 1) << (bits - 1 - b));
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// -----------------------------------------------------------------------------
// fft_frame_bank
// One N x DW register bank holding a single frame. One write port, all
// entries readable in parallel.
//   clk   : system clock
//   rst   : synchronous active-high reset, clears every entry
//   we    : write enable
//   idx   : write index
//   wdata : write data
//   rdata : all entries, entry k at bits [DW*k +: DW]
// -----------------------------------------------------------------------------
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int DW   = FFT_DW,
    parameter int N    = FFT_N,
    parameter int LOGN = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [LOGN-1:0] idx,
    input  logic [DW-1:0]   wdata,
    output logic [N*DW-1:0] rdata
);

    logic [DW-1:0] mem_q [N];
    logic [DW-1:0] mem_d [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[idx] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                mem_q[i] <= '0;
            end else begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < N; i++) begin
            rdata[i*DW +: DW] = mem_q[i];
        end
    end

endmodule

// File: rtl/fft_input_framer.sv
// -----------------------------------------------------------------------------
// fft_input_framer
// Collects a serial stream of signed samples into N-sample frames using two
// ping-pong banks and presents each complete frame as N parallel lanes, held
// until the downstream FFT takes it.
//   clk_1     : system clock
//   rst       : synchronous active-high reset
//   in_data   : serial sample (signed)
//   in_valid  : in_data valid
//   in_sof    : start-of-frame marker, qualified by in_valid
//   in_ready  : a sample can be accepted this cycle
//   out_data  : frame lanes, lane k at bits [DW*k +: DW]
//   out_valid : a complete frame is on out_data
//   out_ready : downstream takes the frame
//   align_err : sticky, a partial frame was discarded by in_sof
// Build option: define FFT_FRAMER_BITREV_EN to present lanes in bit-reversed
// sample order (lane k = sample bitrev(k)); otherwise lane k = sample k.
// -----------------------------------------------------------------------------
module fft_input_framer
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW,
    parameter int N  = FFT_N
) (
    input  logic                 clk_1,
    input  logic                 rst,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_sof,
    output logic                 in_ready,
    output logic [N*DW-1:0]      out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 align_err
);

    localparam int LOGN = $clog2(N);

    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [LOGN-1:0] wr_idx_q, wr_idx_d;
    logic            align_err_q, align_err_d;

    logic [1:0]      bank_we;
    logic [LOGN-1:0] bank_idx;
    logic [N*DW-1:0] bank0_rd, bank1_rd, rd_frame;
    logic            accept, drain;

    assign in_ready  = !rst && !full_q[wr_bank_q];
    assign out_valid = !rst && full_q[rd_bank_q];
    assign align_err = align_err_q;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // Write side fills wr_bank; read side drains rd_bank. A fill can only
    // target a non-full bank, so a fill and a drain in the same cycle always
    // touch different full flags and both apply.
    always_comb begin
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_idx_d    = wr_idx_q;
        align_err_d = align_err_q;
        bank_we     = '0;
        bank_idx    = wr_idx_q;
        if (accept) begin
            bank_we[wr_bank_q] = 1'b1;
            if (in_sof && (wr_idx_q != '0)) begin
                // Restart the frame in the same bank; the partial frame is
                // simply overwritten.
                bank_idx    = '0;
                wr_idx_d    = LOGN'(1);
                align_err_d = 1'b1;
            end else if (wr_idx_q == LOGN'(N-1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_idx_d          = '0;
            end else begin
                wr_idx_d = wr_idx_q + LOGN'(1);
            end
        end
        if (drain) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk_1) begin
        if (rst) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            align_err_q <= 1'b0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            align_err_q <= align_err_d;
        end
    end

    fft_frame_bank #(.DW(DW), .N(N), .LOGN(LOGN)) u_bank0 (
        .clk   (clk_1),
        .rst   (rst),
        .we    (bank_we[0]),
        .idx   (bank_idx),
        .wdata (in_data),
        .rdata (bank0_rd)
    );

    fft_frame_bank #(.DW(DW), .N(N), .LOGN(LOGN)) u_bank1 (
        .clk   (clk_1),
        .rst   (rst),
        .we    (bank_we[1]),
        .idx   (bank_idx),
        .wdata (in_data),
        .rdata (bank1_rd)
    );

    assign rd_frame = rd_bank_q ? bank1_rd : bank0_rd;

    // Lane mapping is wiring only; out_data is forced to zero during reset.
    always_comb begin
        out_data = '0;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
`ifdef FFT_FRAMER_BITREV_EN
                out_data[k*DW +: DW] = rd_frame[bitrev(k, LOGN)*DW +: DW];
`else
                out_data[k*DW +: DW] = rd_frame[k*DW +: DW];
`endif
            end
        end
    end

endmodule
